embcpumem_nios2_qsys_0_nios2_oci_dct_packer: RTL

Upstream of the OCI test-bench monitor. Packs per-branch direct-control-transfer (DCT) codes from the CPU trace port into a 30-bit shift buffer, and presents the live buffer/count (dct_buffer, dct_count) to the monitor. Full or flushed buffers are emitted as frames over a valid/ready handshake toward the trace FIFO. A one-deep frame register decouples accumulation from the downstream stall.

---
 rtl/embcpumem_oci_pkg.sv | 15 +
 rtl/embcpumem_nios2_qsys_0_nios2_oci_dct_frame_reg.sv | 28 ++
 rtl/embcpumem_nios2_qsys_0_nios2_oci_dct_packer.sv | 112 +++++++++++
 3 files changed

// File: rtl/embcpumem_oci_pkg.sv
// embcpumem_oci_pkg: shared DCT packer types and constants.
// Code values, packer state, default geometry and the {count, buffer} frame layout.
package embcpumem_oci_pkg;
    localparam int CODE_W    = 2;
    localparam int MAX_CODES = 15;
    localparam int CNT_W     = 4;
    localparam logic [1:0] DCT_NT = 2'b01;
    localparam logic [1:0] DCT_TK = 2'b10;
    localparam logic [1:0] DCT_EX = 2'b11;
    typedef enum logic [1:0] {DISABLED, ACTIVE, DRAIN} dct_state_t;
    typedef struct packed {
        logic [CNT_W-1:0]            count;
        logic [CODE_W*MAX_CODES-1:0] buffer;
    } dct_frame_t;
endpackage

// File: rtl/embcpumem_nios2_qsys_0_nios2_oci_dct_frame_reg.sv
// embcpumem_nios2_qsys_0_nios2_oci_dct_frame_reg: one-deep valid/ready frame holding register.
// o_free tells the producer a load this cycle is accepted (empty, or draining now).
module embcpumem_nios2_qsys_0_nios2_oci_dct_frame_reg #(
    parameter int DATA_W = 34
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_free
);
    assign o_free = !o_valid || i_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/embcpumem_nios2_qsys_0_nios2_oci_dct_packer.sv
// embcpumem_nios2_qsys_0_nios2_oci_dct_packer: packs branch DCT codes into frames.
// Define EMBCPUMEM_DCT_DROP_CNT_EN to add the saturating drop_cnt output.
module embcpumem_nios2_qsys_0_nios2_oci_dct_packer #(
    parameter int CODE_W    = embcpumem_oci_pkg::CODE_W,
    parameter int MAX_CODES = embcpumem_oci_pkg::MAX_CODES,
    parameter int CNT_W     = embcpumem_oci_pkg::CNT_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              trc_en,
    input  logic                              br_valid,
    input  logic                              br_taken,
    input  logic                              br_excp,
    input  logic                              flush,
    output logic [CODE_W*MAX_CODES-1:0]       dct_buffer,
    output logic [CNT_W-1:0]                  dct_count,
    output logic                              frm_valid,
    input  logic                              frm_ready,
    output logic [CNT_W+CODE_W*MAX_CODES-1:0] frm_data,
    output logic                              ovf
`ifdef EMBCPUMEM_DCT_DROP_CNT_EN
    ,
    output logic [7:0]                        drop_cnt
`endif
);
    import embcpumem_oci_pkg::*;

    localparam int BUF_W = CODE_W*MAX_CODES;
    localparam int FRM_W = CNT_W+BUF_W;

    dct_state_t       r_state;
    dct_state_t       w_next;
    logic [BUF_W-1:0] r_buf;
    logic [CNT_W-1:0] r_count;
    logic             r_pend;
    logic             r_ovf;
    logic             w_free;
    logic             w_active;
    logic             w_drain;
    logic             w_ev;
    logic             w_full;
    logic             w_fl;
    logic             w_req;
    logic             w_incl;
    logic             w_emit;
    logic             w_drop;
    logic [CODE_W-1:0] w_code;
    logic [BUF_W-1:0] w_app_buf;
    logic [FRM_W-1:0] w_frm;

    assign w_active  = r_state == ACTIVE;
    assign w_drain   = r_state == DRAIN;
    assign w_ev      = w_active && br_valid;
    assign w_code    = br_excp ? CODE_W'(DCT_EX) : br_taken ? CODE_W'(DCT_TK) : CODE_W'(DCT_NT);
    assign w_full    = r_count == CNT_W'(MAX_CODES);
    assign w_fl      = w_active && (flush || r_pend);
    assign w_app_buf = {r_buf[BUF_W-CODE_W-1:0], w_code};
    // A flushed event joins the outgoing frame only when it still fits.
    assign w_incl    = w_fl && w_ev && !w_full;
    assign w_req     = w_full || (w_fl && (w_ev || |r_count)) || (w_drain && |r_count);
    assign w_emit    = w_req && w_free;
    assign w_drop    = w_ev && w_full && !w_free;
    assign w_frm     = w_incl ? {r_count + CNT_W'(1), w_app_buf} : {r_count, r_buf};
    assign w_next    = (r_state == DISABLED) ? (trc_en ? ACTIVE : DISABLED)
                     : w_active ? (trc_en ? ACTIVE : DRAIN)
                     : ((w_emit || r_count == '0) ? DISABLED : DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= DISABLED;
            r_buf   <= '0;
            r_count <= '0;
            r_pend  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_emit) begin
                r_buf   <= (w_ev && w_full) ? BUF_W'(w_code) : '0;
                r_count <= (w_ev && w_full) ? CNT_W'(1) : '0;
            end else if (w_ev && !w_full) begin
                r_buf   <= w_app_buf;
                r_count <= r_count + CNT_W'(1);
            end
            r_pend <= w_fl && w_req && !w_emit;
            if (w_drop) r_ovf <= 1'b1;
        end
    end

`ifdef EMBCPUMEM_DCT_DROP_CNT_EN
    logic [7:0] r_drop;
    always_ff @(posedge clk) begin
        if (reset) r_drop <= '0;
        else if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
    assign drop_cnt = r_drop;
`endif

    assign dct_buffer = r_buf;
    assign dct_count  = r_count;
    assign ovf        = r_ovf;

    embcpumem_nios2_qsys_0_nios2_oci_dct_frame_reg #(.DATA_W(FRM_W)) u_frame_reg (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_emit),
        .i_data  (w_frm),
        .i_ready (frm_ready),
        .o_valid (frm_valid),
        .o_data  (frm_data),
        .o_free  (w_free)
    );
endmodule
